onchip_memory_pipelined: RTL
============================

Name: onchip_memory_pipelined

Overview:
- Parametrised Avalon-MM on-chip RAM slave. It is the successor to the fixed 2048x32 single-port on-chip memory.
- Adds:
  - configurable width and depth
  - selectable read latency (1 or 2) with a readdatavalid strobe
  - clock-enable stall of the whole pipeline
  - a hardware clear-on-reset engine that holds waitrequest while it zeroes the array
- Sits on the system interconnect as a program/data memory slave.
- Uses an inferred RAM array; no vendor primitive.

Parameters:
DATA_W, 32, data width in bits; multiple of 8
DEPTH, 2048, number of words; need not be a power of 2
ADDR_W, 11, address width; must satisfy 2**ADDR_W >= DEPTH
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = clear the array after reset; 0 = no clear, ready immediately
CLEAR_VALUE, 0, DATA_W-bit word written to every location during clear

Ports:
clk  in  1  single clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  per-byte write enables
writedata  in  DATA_W  write data
clken  in  1  global clock enable; 0 freezes all state
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata valid strobe
waitrequest  out  1  slave busy; no transfer accepted while 1
clearing  out  1  clear engine active (status/debug)

Behaviour:
- Reset values (async, while reset=1):
  - readdata=0, readdatavalid=0, read pipeline valid flags=0, clear counter=0.
  - waitrequest=1, clearing=CLEAR_ON_RESET.
  - RAM contents are not reset.
- FSM states:
  - CLEAR (entry state if CLEAR_ON_RESET=1): on each clk with clken=1, write CLEAR_VALUE (all bytes) to counter address, then counter+1. Leave to READY after writing DEPTH-1.
    - The clear takes exactly DEPTH clken-high cycles.
    - waitrequest=1 and clearing=1 throughout CLEAR.
    - First cycle of READY: waitrequest=0, clearing=0.
  - READY (entry state if CLEAR_ON_RESET=0, with waitrequest=0 on the first clk after reset release): serves transfers; waitrequest=0. READY is terminal until the next reset.
- Reset asserted mid-clear: the clear aborts, and after release it restarts from address 0. Reset mid-read discards in-flight reads; no readdatavalid for them.
- Acceptance: a transfer is accepted in a cycle where chipselect=1, (read|write)=1, waitrequest=0 and clken=1. Requests in cycles with clken=0 are not accepted and have no effect; the master must hold them.
- Write:
  - Byte lane i is updated iff byteenable[i]=1.
  - byteenable=0 gives no change.
  - write=1 and read=1 together: the write is performed and the read is ignored (no readdatavalid).
- Out-of-range address (address >= DEPTH): writes are dropped; reads complete normally and return 0.
- Read:
  - The RAM is read synchronously.
  - READ_LATENCY=1: data and its valid flag are produced at the edge accepting the read.
  - READ_LATENCY=2: one extra output register stage follows.
  - The pipeline advances only on cycles with clken=1.
  - readdatavalid = last-stage valid flag AND clken. Each read is reported exactly once, in the first clken-high cycle after it reaches the last stage.
  - With clken=1 continuously, readdatavalid rises READ_LATENCY cycles after the accepting cycle.
  - Back-to-back reads stream one per cycle.
- readdata holds its last value between strobes; it is only updated when a valid word enters the last stage.
- Write at address A in cycle N, then read of A in cycle N+1 or later, returns the newly written data.
- clken=0 freezes everything, including the clear counter, FSM state and pipeline; readdatavalid is forced 0.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16, CLEAR_VALUE=32'hA5A5A5A5:
  - Release reset: waitrequest=1 for exactly 16 cycles, then 0.
  - Read all 16 addresses: every word = A5A5A5A5.
- Byte lanes: write 32'h11223344 to addr 5 with byteenable=4'b1111, then write 32'hAABBCCDD with byteenable=4'b0101, then read addr 5 -> 32'h11BB33DD.
- Latency: for READ_LATENCY=1 and 2, issue 4 back-to-back reads of addrs 0-3 (preloaded 0,1,2,3).
  - readdatavalid goes high 1 (resp. 2) cycles later for 4 consecutive cycles, with data 0,1,2,3.
- Stall: with READ_LATENCY=2, accept a read, then drop clken for 3 cycles.
  - readdatavalid stays 0 during the stall.
  - It pulses once with the correct data on the first cycle clken=1.
- Reset mid-clear: assert reset at clear address 7 (DEPTH=16).
  - After release, waitrequest is held for 16 full cycles.
- Edge cases:
  - Read of addr 20 (DEPTH=16, ADDR_W=5) returns 0; a write to it does not alias addr 4.
  - read=1 and write=1 together: the write lands and no readdatavalid is generated.

Source files
------------

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM on-chip RAM slave with configurable geometry, 1- or 2-cycle read
// latency with a readdatavalid strobe, a global clock enable that freezes all
// state, and an optional engine that fills the array with CLEAR_VALUE after
// reset while holding waitrequest.
module onchip_memory_pipelined #(
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       DEPTH          = 2048,
    parameter int unsigned       ADDR_W         = 11,
    parameter int unsigned       READ_LATENCY   = 1,
    parameter int unsigned       CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                clearing
);

    localparam int unsigned BYTES = DATA_W / 8;
    // Array index width; the upper address bits only feed the range check.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {StClear, StReady} state_e;

    localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? StClear : StReady;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    // Registered so waitrequest stays high during reset even when there is no clear.
    logic              ready_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              accept;
    logic              wr_accept;
    logic              rd_accept;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [BYTES-1:0]  wr_be;

    logic              s1_valid_q, s2_valid_q;
    logic [DATA_W-1:0] s1_data_q, s2_data_q;

    // Transfer decode: a read that coincides with a write is dropped.
    always_comb begin
        in_range  = ({1'b0, address} < DEPTH_EXT);
        accept    = chipselect & (read | write) & ready_q & clken;
        wr_accept = accept & write;
        rd_accept = accept & read & ~write;
    end

    // FSM state register, clear counter and ready flag; all frozen when clken=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else if (clken) begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == StReady);
        end
    end

    // FSM next state: step through the array once, then serve transfers forever.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    // FSM outputs and read-side output selection.
    always_comb begin
        waitrequest = ~ready_q;
        clearing    = (state_q == StClear);
        if (READ_LATENCY == 2) begin
            readdata      = s2_data_q;
            readdatavalid = s2_valid_q & clken;
        end else begin
            readdata      = s1_data_q;
            readdatavalid = s1_valid_q & clken;
        end
    end

    // Single write port shared by the clear engine and bus writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = address[IDX_W-1:0];
        wr_data = writedata;
        wr_be   = byteenable;
        if (state_q == StClear) begin
            wr_en   = clken & ~reset;
            wr_idx  = clr_cnt_q;
            wr_data = CLEAR_VALUE;
            wr_be   = '1;
        end else begin
            wr_en = wr_accept & in_range;
        end
    end

    // RAM array write with per-byte enables; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: synchronous RAM read into stage 1, optional output stage 2.
    // Data registers load only alongside a valid word so readdata holds between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else if (clken) begin
            s1_valid_q <= rd_accept;
            if (rd_accept) begin
                s1_data_q <= in_range ? mem[address[IDX_W-1:0]] : '0;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
            end
        end
    end

endmodule
